// File: rtl/seq_radix4_multiplier_if.sv
// Operand/product handshake bundle for seq_radix4_multiplier.
// The master drives operands and out_ready. The slave (the multiplier) drives in_ready, the product and busy.
interface seq_radix4_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] O;
  logic               busy;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, O, busy
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, O, busy
  );
endinterface

// File: rtl/seq_radix4_multiplier.sv
// Iterative unsigned multiplier that retires one 2-bit digit of B per clock.
// Handshake: a pair transfers on in_valid && in_ready, and a product transfers on out_valid && out_ready.
module seq_radix4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_radix4_multiplier_if.slave bus
);

  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

  if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
    $error("seq_radix4_multiplier: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pp;
  logic               last_digit;

  assign last_digit = (cnt == CW'(WIDTH / 2 - 1));

  // A_sh times one radix-4 digit. A_sh is already scaled to the digit's weight, so no truncation occurs.
  always_comb begin
    pp = '0;
    unique case (b_sh[1:0])
      2'd0: pp = '0;
      2'd1: pp = a_sh;
      2'd2: pp = a_sh << 1;
      2'd3: pp = a_sh + (a_sh << 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = BUSY;
      BUSY:    if (last_digit)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      p    <= '0;
      cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh <= {{WIDTH{1'b0}}, bus.A};
            b_sh <= bus.B;
            p    <= '0;
            cnt  <= '0;
          end
        end
        BUSY: begin
          p    <= p + pp;
          a_sh <= a_sh << 2;
          b_sh <= b_sh >> 2;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // P is left intact after DONE, so O keeps showing the last product while the block is idle.
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == BUSY);
  assign bus.out_valid = (state == DONE);
  assign bus.O         = p;

endmodule

// File: tb/tb_seq_radix4_multiplier.sv
// Self-checking bench for seq_radix4_multiplier at WIDTH = 2, 8 and 16.
// Each expected product is queued when its operands are accepted and is checked when the result is consumed.
module tb_seq_radix4_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_radix4_multiplier_if #(.WIDTH(2))  w2 ();
  seq_radix4_multiplier_if #(.WIDTH(8))  w8 ();
  seq_radix4_multiplier_if #(.WIDTH(16)) w16 ();

  seq_radix4_multiplier #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(w2.slave));
  seq_radix4_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(w8.slave));
  seq_radix4_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(w16.slave));

  // index 0: WIDTH 2, 1: WIDTH 8, 2: WIDTH 16
  logic        iv  [3];
  logic        orr [3];
  logic [15:0] av, bv;
  logic        rdy [3];
  logic        ov  [3];
  logic        bsy [3];
  logic [31:0] o   [3];

  assign w2.in_valid   = iv[0];
  assign w2.A          = av[1:0];
  assign w2.B          = bv[1:0];
  assign w2.out_ready  = orr[0];
  assign w8.in_valid   = iv[1];
  assign w8.A          = av[7:0];
  assign w8.B          = bv[7:0];
  assign w8.out_ready  = orr[1];
  assign w16.in_valid  = iv[2];
  assign w16.A         = av;
  assign w16.B         = bv;
  assign w16.out_ready = orr[2];

  assign rdy[0] = w2.in_ready;
  assign rdy[1] = w8.in_ready;
  assign rdy[2] = w16.in_ready;
  assign ov[0]  = w2.out_valid;
  assign ov[1]  = w8.out_valid;
  assign ov[2]  = w16.out_valid;
  assign bsy[0] = w2.busy;
  assign bsy[1] = w8.busy;
  assign bsy[2] = w16.busy;
  assign o[0]   = 32'(w2.O);
  assign o[1]   = 32'(w8.O);
  assign o[2]   = 32'(w16.O);

  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] ref_mul(input int sel, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] mask;
    mask = (sel == 0) ? 16'h0003 : (sel == 1) ? 16'h00ff : 16'hffff;
    return 32'(a & mask) * 32'(b & mask);
  endfunction

  task automatic submit(input int sel, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[sel] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[sel]) begin
      checks++; errors++;
      $display("FAIL submit_timeout sel=%0d in_ready=%0b required=1", sel, rdy[sel]);
      return;
    end
    iv[sel] = 1'b1;
    av = a;
    bv = b;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
    exp_q.push_back(ref_mul(sel, a, b));
  endtask

  // Call right after submit: counts edges after the accept edge until out_valid is high.
  task automatic check_latency(input int sel, input int lat, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ov[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d required=%0d", name, n, lat);
    end
  endtask

  task automatic take(input int sel, input int stall, input string name);
    int n;
    logic [31:0] e;
    n = 0;
    while (!ov[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ov[sel]) begin
      checks++; errors++;
      $display("FAIL %s_out_timeout out_valid=%0b required=1", name, ov[sel]);
      return;
    end
    repeat (stall) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_output got=%0h required=none", name, o[sel]);
    end else begin
      e = exp_q.pop_front();
      if (o[sel] !== e) begin
        errors++;
        $display("FAIL %s_product got=%0h required=%0h", name, o[sel], e);
      end
    end
    orr[sel] = 1'b1;
    @(posedge clk);
    #1;
    orr[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks += 4;
      if (ov[s] !== 1'b0)   begin errors++; $display("FAIL reset_out_valid sel=%0d got=%0b required=0", s, ov[s]); end
      if (o[s] !== 32'd0)   begin errors++; $display("FAIL reset_O sel=%0d got=%0h required=0", s, o[s]); end
      if (bsy[s] !== 1'b0)  begin errors++; $display("FAIL reset_busy sel=%0d got=%0b required=0", s, bsy[s]); end
      if (rdy[s] !== 1'b1)  begin errors++; $display("FAIL reset_in_ready sel=%0d got=%0b required=1", s, rdy[s]); end
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_w2_exhaustive();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        submit(0, 16'(a), 16'(b));
        check_latency(0, 1, "w2");
        take(0, 0, "w2");
      end
    end
  endtask

  task automatic test_w8_cases();
    submit(1, 16'h00ff, 16'h00ff);
    check_latency(1, 4, "w8_max");
    checks++;
    if (o[1] !== 32'h0000fe01) begin errors++; $display("FAIL w8_max_const got=%0h required=fe01", o[1]); end
    take(1, 0, "w8_max");
    submit(1, 16'h00b7, 16'h005c);
    check_latency(1, 4, "w8_b7x5c");
    checks++;
    if (o[1] !== 32'h000041c4) begin errors++; $display("FAIL w8_b7x5c_const got=%0h required=41c4", o[1]); end
    take(1, 0, "w8_b7x5c");
    submit(1, 16'h0000, 16'h00ff);
    check_latency(1, 4, "w8_zero");
    take(1, 0, "w8_zero");
  endtask

  task automatic test_backpressure();
    submit(1, 16'd7, 16'd9);
    check_latency(1, 4, "bp");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks += 3;
      if (ov[1] !== 1'b1)      begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%0b required=1", i, ov[1]); end
      if (o[1] !== 32'd63)     begin errors++; $display("FAIL bp_O cyc=%0d got=%0h required=3f", i, o[1]); end
      if (rdy[1] !== 1'b0)     begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%0b required=0", i, rdy[1]); end
    end
    take(1, 0, "bp");
    @(negedge clk);
    checks += 3;
    if (rdy[1] !== 1'b1)  begin errors++; $display("FAIL bp_idle_in_ready got=%0b required=1", rdy[1]); end
    if (ov[1] !== 1'b0)   begin errors++; $display("FAIL bp_idle_out_valid got=%0b required=0", ov[1]); end
    if (o[1] !== 32'd63)  begin errors++; $display("FAIL bp_idle_O_kept got=%0h required=3f", o[1]); end
  endtask

  task automatic test_ignore_busy();
    submit(1, 16'd12, 16'd10);
    iv[1] = 1'b1;
    av = 16'd1;
    bv = 16'd1;
    repeat (2) @(posedge clk);
    #1;
    iv[1] = 1'b0;
    checks++;
    if (o[1] === 32'd1) begin errors++; $display("FAIL busy_intermediate got=%0h required=not 1", o[1]); end
    take(1, 0, "busy_ignore");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks += 2;
      if (ov[1] !== 1'b0)  begin errors++; $display("FAIL busy_extra_out_valid cyc=%0d got=%0b required=0", i, ov[1]); end
      if (rdy[1] !== 1'b1) begin errors++; $display("FAIL busy_extra_in_ready cyc=%0d got=%0b required=1", i, rdy[1]); end
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL busy_queue got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    submit(1, 16'd200, 16'd200);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks += 4;
    if (rdy[1] !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%0b required=1", rdy[1]); end
    if (ov[1] !== 1'b0)  begin errors++; $display("FAIL rstmid_out_valid got=%0b required=0", ov[1]); end
    if (o[1] !== 32'd0)  begin errors++; $display("FAIL rstmid_O got=%0h required=0", o[1]); end
    if (bsy[1] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b required=0", bsy[1]); end
    submit(1, 16'd3, 16'd5);
    check_latency(1, 4, "rstmid_next");
    checks++;
    if (o[1] !== 32'd15) begin errors++; $display("FAIL rstmid_next_const got=%0h required=f", o[1]); end
    take(1, 0, "rstmid_next");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [15:0] a, b;
          a = (i == 0) ? 16'hffff : 16'($urandom_range(0, 65535));
          b = (i == 0) ? 16'hffff : 16'($urandom_range(0, 65535));
          submit(2, a, b);
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          take(2, int'($urandom_range(0, 3)), "b2b");
        end
      end
    join
    repeat (10) @(negedge clk);
    checks += 2;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got=%0d required=0", exp_q.size()); end
    if (ov[2] !== 1'b0)     begin errors++; $display("FAIL b2b_duplicate out_valid=%0b required=0", ov[2]); end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      iv[s]  = 1'b0;
      orr[s] = 1'b0;
    end
    av = '0;
    bv = '0;
    test_reset();
    test_w2_exhaustive();
    test_w8_cases();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

endmodule
